// File: rtl/gol_array_ctrl_if.sv
// Host-side handshakes of gol_array_ctrl: command channel, load bit stream
// and readout bit stream.
interface gol_array_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             din_valid;
  logic             din_ready;
  logic             din_data;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, din_valid, din_data, dout_ready,
    input  cmd_ready, din_ready, dout_valid, dout_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, din_valid, din_data, dout_ready,
    output cmd_ready, din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/gol_array_ctrl.sv
// Sequencer for the Game of Life shift-chain cell array: clear, load, run N
// generations, non-destructive readout. GOL_GEN_COUNTER_EN adds gen_total.
module gol_array_ctrl #(
  parameter int CELLS = 64,
  parameter int CNT_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  gol_array_ctrl_if.slave host,
  input  logic            array_out,
  output logic            shift,
  output logic            next_tick,
  output logic            data_in,
  output logic            busy,
  output logic            done
`ifdef GOL_GEN_COUNTER_EN
  ,
  output logic [31:0]     gen_total
`endif
);
  localparam int              BW    = $clog2(CELLS + 1);
  localparam logic [BW-1:0]   BEATS = BW'(CELLS);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_READ
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] gen_q, gen_d;
  logic             accept;
  logic             cmd_ready_c, din_ready_c, dout_valid_c, dout_data_c;
  op_e              op;

  assign op     = op_e'(host.cmd_op);
  assign accept = (state_q == S_IDLE) && host.cmd_valid;
  assign busy   = (state_q != S_IDLE);

  assign host.cmd_ready  = cmd_ready_c;
  assign host.din_ready  = din_ready_c;
  assign host.dout_valid = dout_valid_c;
  assign host.dout_data  = dout_data_c;

  // Every busy state ends with one quiet cycle (counter at zero) that carries
  // done, so done never overlaps an IDLE cycle in which a command could land.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    gen_d        = gen_q;
    cmd_ready_c  = 1'b0;
    din_ready_c  = 1'b0;
    dout_valid_c = 1'b0;
    dout_data_c  = 1'b0;
    shift        = 1'b0;
    next_tick    = 1'b0;
    data_in      = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (host.cmd_valid) begin
          case (op)
            OP_CLEAR: begin state_d = S_CLR;  beat_d = BEATS; end
            OP_LOAD:  begin state_d = S_LOAD; beat_d = BEATS; end
            OP_RUN:   begin state_d = S_RUN;  gen_d  = host.cmd_count; end
            OP_READ:  begin state_d = S_READ; beat_d = BEATS; end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_CLR: begin
        if (beat_q != '0) begin
          shift  = 1'b1;
          beat_d = beat_q - BW'(1);
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        data_in = host.din_data;
        if (beat_q != '0) begin
          din_ready_c = 1'b1;
          shift       = host.din_valid;
          if (host.din_valid) beat_d = beat_q - BW'(1);
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (gen_q != '0) begin
          next_tick = 1'b1;
          gen_d     = gen_q - CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // Feeding the last cell back into the first makes a full pass a rotation.
        dout_data_c = array_out;
        data_in     = array_out;
        if (beat_q != '0) begin
          dout_valid_c = 1'b1;
          shift        = host.dout_ready;
          if (host.dout_ready) beat_d = beat_q - BW'(1);
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gen_q   <= gen_d;
    end
  end

`ifdef GOL_GEN_COUNTER_EN
  logic [31:0] gen_total_q, gen_total_d;

  always_comb begin
    gen_total_d = gen_total_q;
    if (accept && (op == OP_CLEAR || op == OP_LOAD)) gen_total_d = '0;
    else if (next_tick)                              gen_total_d = gen_total_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) gen_total_q <= '0;
    else       gen_total_q <= gen_total_d;
  end

  assign gen_total = gen_total_q;
`endif
endmodule

// File: tb/tb_gol_array_ctrl.sv
// Bench for gol_array_ctrl on a 4x4 board: models the cell array, checks the
// control outputs every cycle and the board contents per transaction.
module tb_gol_array_ctrl;
  localparam int CELLS = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 16;
  localparam int P_IDLE = 0, P_CLR = 1, P_LOAD = 2, P_RUN = 3, P_READ = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gol_array_ctrl_if #(.CNT_W(CNT_W)) bus ();
  logic array_out, shift, next_tick, data_in, busy, done;
`ifdef GOL_GEN_COUNTER_EN
  logic [31:0] gen_total;
`endif

  gol_array_ctrl #(.CELLS(CELLS), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .host      (bus),
    .array_out (array_out),
    .shift     (shift),
    .next_tick (next_tick),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
`ifdef GOL_GEN_COUNTER_EN
    ,
    .gen_total (gen_total)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int shift_cnt = 0, tick_cnt = 0, gap_shift = 0;
  logic [CELLS-1:0] board     = '0;  // the cell array itself
  logic [CELLS-1:0] ref_chain = '0;  // expected board, per transaction
  int ph = P_IDLE;
  int rem = 0;
  logic [31:0] egen = '0;

  function automatic logic [CELLS-1:0] life(input logic [CELLS-1:0] b);
    logic [CELLS-1:0] nb;
    int nbrs, rr, cc;
    nb = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        nbrs = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              nbrs += int'(b[rr*COLS+cc]);
          end
        nb[r*COLS+c] = (nbrs == 3) || (b[r*COLS+c] && nbrs == 2);
      end
    return nb;
  endfunction

  // Stream bit k is the k-th bit in (load) or out (read); chain bit i is cell i.
  function automatic logic [CELLS-1:0] rev(input logic [CELLS-1:0] v);
    logic [CELLS-1:0] r;
    for (int i = 0; i < CELLS; i++) r[i] = v[CELLS-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  assign array_out = board[CELLS-1];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (shift)          board <= {board[CELLS-2:0], data_in};
    else if (next_tick) board <= life(board);
  end

  // Abstract command-progress model: which command is running and how much work is left.
  always @(posedge clock) begin
    if (reset) begin
      ph   <= P_IDLE;
      rem  <= 0;
      egen <= '0;
    end else begin
      case (ph)
        P_IDLE: if (bus.cmd_valid) begin
          ph  <= int'(bus.cmd_op) + 1;
          rem <= (bus.cmd_op == 2'b10) ? int'(bus.cmd_count) : CELLS;
          if (bus.cmd_op == 2'b00 || bus.cmd_op == 2'b01) egen <= '0;
        end
        P_CLR, P_RUN: begin
          if (rem == 0) ph <= P_IDLE;
          else          rem <= rem - 1;
          if (ph == P_RUN && rem != 0) egen <= egen + 32'd1;
        end
        P_LOAD: if (rem == 0) ph <= P_IDLE; else if (bus.din_valid)  rem <= rem - 1;
        P_READ: if (rem == 0) ph <= P_IDLE; else if (bus.dout_ready) rem <= rem - 1;
        default: ph <= P_IDLE;
      endcase
    end
  end

  initial begin : compare
    logic act_w, e_shift, e_din;
    forever begin
      @(negedge clock);
      if (!reset) begin
        act_w   = (rem != 0);
        e_shift = 1'b0;
        e_din   = 1'b0;
        case (ph)
          P_CLR:  e_shift = act_w;
          P_LOAD: begin e_shift = act_w & bus.din_valid;  e_din = bus.din_data; end
          P_READ: begin e_shift = act_w & bus.dout_ready; e_din = array_out;    end
          default: ;
        endcase
        chk("cmd_ready",  bus.cmd_ready,  ph == P_IDLE);
        chk("busy",       busy,           ph != P_IDLE);
        chk("done",       done,           ph != P_IDLE && !act_w);
        chk("shift",      shift,          e_shift);
        chk("next_tick",  next_tick,      ph == P_RUN && act_w);
        chk("din_ready",  bus.din_ready,  ph == P_LOAD && act_w);
        chk("dout_valid", bus.dout_valid, ph == P_READ && act_w);
        chk("dout_data",  bus.dout_data,  (ph == P_READ) ? array_out : 1'b0);
        chk("shift_tick_exclusive", shift & next_tick, 0);
        if (e_shift) chk("data_in", data_in, e_din);
`ifdef GOL_GEN_COUNTER_EN
        chk("gen_total", gen_total, egen);
`endif
      end
      if (shift)     shift_cnt++;
      if (next_tick) tick_cnt++;
      if (ph == P_LOAD && !bus.din_valid && shift) gap_shift++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clock);
      if (bus.cmd_ready) begin ok = 1'b1; acc = cyc; end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_count = CNT_W'($urandom);
    chk("cmd_accepted", {31'b0, ok}, 1);
  endtask

  task automatic wait_done(input int bound, output int d);
    bit seen;
    seen = 1'b0;
    d = -1;
    for (int g = 0; g < bound && !seen; g++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; d = cyc; end
      step();
    end
    chk("done_seen", {31'b0, seen}, 1);
  endtask

  // mode 0: din_valid always high, 1: every other cycle, 2: random
  task automatic do_load(input logic [CELLS-1:0] p, input int mode, input int nbeats,
                         output int last);
    int i, a;
    i = 0;
    last = -1;
    send_cmd(2'b01, '0, a);
    for (int g = 0; g < 400 && i < nbeats; g++) begin
      bus.din_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      bus.din_data  = bus.din_valid ? p[i] : 1'($urandom);
      @(negedge clock);
      if (bus.din_valid && bus.din_ready) begin i++; last = cyc; end
      step();
    end
    bus.din_valid = 1'b0;
    chk("load_beats", i, nbeats);
  endtask

  task automatic do_read(output logic [CELLS-1:0] stream);
    int k, a, d;
    logic [CELLS-1:0] s;
    k = 0;
    s = '0;
    send_cmd(2'b11, '0, a);
    for (int g = 0; g < 400 && k < CELLS; g++) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (bus.dout_valid && bus.dout_ready) begin s[k] = bus.dout_data; k++; end
      step();
    end
    bus.dout_ready = 1'b0;
    chk("read_beats", k, CELLS);
    wait_done(5, d);
    stream = s;
  endtask

  initial begin
    int a, d, last, s0, t0, n;
    logic [CELLS-1:0] st, st2, p;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_count  = '0;
    bus.din_valid  = 1'b0;
    bus.din_data   = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // reset state after idling
    repeat (5) step();
    @(negedge clock);
    chk("rst_cmd_ready",  bus.cmd_ready, 1);
    chk("rst_busy",       busy, 0);
    chk("rst_shift",      shift, 0);
    chk("rst_next_tick",  next_tick, 0);
    chk("rst_done",       done, 0);
    chk("rst_din_ready",  bus.din_ready, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    step();

    // horizontal blinker load with gaps
    s0 = shift_cnt;
    do_load(16'h0070, 1, CELLS, last);
    wait_done(5, d);
    chk("load_shift_count", shift_cnt - s0, CELLS);
    chk("load_gap_shifts", gap_shift, 0);
    chk("load_done_latency", d - last, 1);
    ref_chain = rev(16'h0070);
    do_read(st);
    chk("read_after_load", st, 16'h0070);

    // three generations: blinker ends vertical
    t0 = tick_cnt; s0 = shift_cnt;
    send_cmd(2'b10, 16'd3, a);
    wait_done(10, d);
    chk("run3_ticks", tick_cnt - t0, 3);
    chk("run3_shifts", shift_cnt - s0, 0);
    chk("run3_latency", d - a, 4);
`ifdef GOL_GEN_COUNTER_EN
    chk("gen_total_run3", gen_total, 3);
`endif
    repeat (3) ref_chain = life(ref_chain);
    do_read(st);
    chk("read_vertical_blinker", st, 16'h0222);
    chk("read_vs_model", st, rev(ref_chain));
    do_read(st2);
    chk("second_read_identical", st2, st);

    // zero-generation run
    t0 = tick_cnt;
    send_cmd(2'b10, 16'd0, a);
    wait_done(5, d);
    chk("run0_ticks", tick_cnt - t0, 0);
    chk("run0_latency", d - a, 1);

    // clear
    s0 = shift_cnt;
    send_cmd(2'b00, '0, a);
    wait_done(CELLS + 5, d);
    chk("clear_latency", d - a, CELLS + 1);
    chk("clear_shift_count", shift_cnt - s0, CELLS);
    ref_chain = '0;
    do_read(st);
    chk("read_after_clear", st, 16'h0000);
`ifdef GOL_GEN_COUNTER_EN
    chk("gen_total_clear", gen_total, 0);
`endif

    // random boards, gap patterns and run lengths
    for (int t = 0; t < 8; t++) begin
      p = CELLS'($urandom);
      do_load(p, $urandom_range(0, 2), CELLS, last);
      wait_done(5, d);
      chk("rand_load_latency", d - last, 1);
      ref_chain = rev(p);
      n = $urandom_range(0, 6);
      t0 = tick_cnt;
      send_cmd(2'b10, CNT_W'(n), a);
      wait_done(n + 5, d);
      chk("rand_run_latency", d - a, n + 1);
      chk("rand_run_ticks", tick_cnt - t0, n);
      for (int g = 0; g < n; g++) ref_chain = life(ref_chain);
`ifdef GOL_GEN_COUNTER_EN
      chk("rand_gen_total", gen_total, n);
`endif
      do_read(st);
      chk("rand_read", st, rev(ref_chain));
    end

    // reset in the middle of a load
    do_load(16'hA5C3, 0, 7, last);
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("midrst_cmd_ready",  bus.cmd_ready, 1);
    chk("midrst_busy",       busy, 0);
    chk("midrst_shift",      shift, 0);
    chk("midrst_din_ready",  bus.din_ready, 0);
    chk("midrst_dout_valid", bus.dout_valid, 0);
    chk("midrst_done",       done, 0);
    step();
    reset = 1'b0;
    p = 16'h3C96;
    do_load(p, 2, CELLS, last);
    wait_done(5, d);
    chk("post_reset_load_latency", d - last, 1);
    do_read(st);
    chk("post_reset_read", st, p);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
